adc_capture_ctrl: RTL and testbench

// Multi-channel triggered capture engine for the DSP-clock domain; successor to the single-channel free-running BRAM writer.

---
 rtl/capture_pkg.sv | 18 +
 rtl/decim_strobe.sv | 32 +++
 rtl/adc_capture_ctrl.sv | 150 +++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and helpers for the triggered capture engine.
//   capstate_t : capture state machine encoding
//   depth_of   : buffer depth for a given word address width
package capture_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      WAIT = 3'd2,
      POST = 3'd3,
      DONE = 3'd4
   } capstate_t;

   function automatic int unsigned depth_of(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/decim_strobe.sv
// Decimation strobe: passes one of every (ratio+1) valid cycles.
//   clk, aresetn : clock and synchronous active-low reset
//   valid        : a sample is present this cycle
//   load         : clear the counter so the next valid cycle is accepted
//   ratio        : reload value applied on every accepted sample
//   accept       : this valid cycle carries a kept sample
module decim_strobe #(
   parameter int DECIM_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   valid,
   input  logic                   load,
   input  logic [DECIM_WIDTH-1:0] ratio,
   output logic                   accept
);

   logic [DECIM_WIDTH-1:0] count_reg;

   assign accept = valid && (count_reg == '0);

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= '0;
      end else if (valid) begin
         count_reg <= accept ? ratio : count_reg - DECIM_WIDTH'(1);
      end
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Multi-channel triggered capture engine writing NCH circular BRAMs.
//   clk, aresetn        : DSP clock, synchronous active-low reset
//   in_valid, in_data   : parallel channel samples (channel c at c*DATA_WIDTH)
//   arm, abort, trig    : capture control; trig is qualified by an accepted sample
//   pretrig, decim, chen: capture setup, latched when an arm is taken
//   bram_addr/data/we   : registered BRAM write port shared by all channels
//   busy, done          : capture in progress / buffer full
//   start_addr          : oldest sample of the captured window
//   trig_addr           : address of the trigger sample
module adc_capture_ctrl
   import capture_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 14,
   parameter int DECIM_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      aresetn,
   input  logic                      in_valid,
   input  logic [NCH*DATA_WIDTH-1:0] in_data,
   input  logic                      arm,
   input  logic                      abort,
   input  logic                      trig,
   input  logic [ADDR_WIDTH-1:0]     pretrig,
   input  logic [DECIM_WIDTH-1:0]    decim,
   input  logic [NCH-1:0]            chen,
   output logic [ADDR_WIDTH-1:0]     bram_addr,
   output logic [NCH*DATA_WIDTH-1:0] bram_data,
   output logic [NCH-1:0]            bram_we,
   output logic                      busy,
   output logic                      done,
   output logic [ADDR_WIDTH-1:0]     start_addr,
   output logic [ADDR_WIDTH-1:0]     trig_addr
);

   localparam int unsigned            DEPTH    = depth_of(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0]  ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0]  ONE      = ADDR_WIDTH'(1);

   capstate_t               state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   ptr_reg;
   logic [ADDR_WIDTH-1:0]   count_reg;
   logic [ADDR_WIDTH-1:0]   pretrig_reg;
   logic [DECIM_WIDTH-1:0]  decim_reg;
   logic [NCH-1:0]          chen_reg;
   logic [ADDR_WIDTH-1:0]   post_len;
   logic                    accept;
   logic                    arm_go;
   logic                    pre_last;
   logic                    post_full;
   logic                    write_en;

   // An arm is only taken when idle or finished; abort always wins.
   assign arm_go = arm && !abort && ((state_reg == IDLE) || (state_reg == DONE));

   // pretrig is already bounded to DEPTH-1 by its port width, so
   // the post-trigger length never underflows.
   assign post_len  = ADDR_MAX - pretrig_reg;
   assign pre_last  = (count_reg == pretrig_reg - ONE);
   assign post_full = (count_reg == post_len);

   decim_strobe #(
      .DECIM_WIDTH(DECIM_WIDTH)
   ) u_decim (
      .clk    (clk),
      .aresetn(aresetn),
      .valid  (in_valid),
      .load   (arm_go),
      .ratio  (decim_reg),
      .accept (accept)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE, DONE: if (arm) state_next = (pretrig == '0) ? WAIT : PRE;
            // Leave PRE on the sample that completes the pre-trigger block
            // so the very next sample is already trigger-eligible.
            PRE:        if (accept && pre_last) state_next = WAIT;
            WAIT:       if (accept && trig) state_next = POST;
            // Exit on the registered count: done rises the cycle after
            // the final bram_we, and a zero-length POST writes nothing.
            POST:       if (post_full) state_next = DONE;
            default:    state_next = IDLE;
         endcase
      end
   end

   // Output decode
   always_comb begin
      busy     = (state_reg == PRE) || (state_reg == WAIT) || (state_reg == POST);
      done     = (state_reg == DONE);
      write_en = accept && !abort &&
                 ((state_reg == PRE) || (state_reg == WAIT) ||
                  ((state_reg == POST) && !post_full));
   end

   // Datapath: pointer, counters, setup latches and registered write port
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         ptr_reg     <= '0;
         count_reg   <= '0;
         pretrig_reg <= '0;
         decim_reg   <= '0;
         chen_reg    <= '0;
         bram_addr   <= '0;
         bram_data   <= '0;
         bram_we     <= '0;
         start_addr  <= '0;
         trig_addr   <= '0;
      end else begin
         bram_we <= write_en ? chen_reg : '0;
         if (arm_go) begin
            pretrig_reg <= pretrig;
            decim_reg   <= decim;
            chen_reg    <= chen;
            ptr_reg     <= '0;
            count_reg   <= '0;
         end else if (write_en) begin
            bram_addr <= ptr_reg;
            bram_data <= in_data;
            ptr_reg   <= ptr_reg + ONE;
            case (state_reg)
               PRE:     count_reg <= pre_last ? '0 : count_reg + ONE;
               POST:    count_reg <= count_reg + ONE;
               default: count_reg <= '0;
            endcase
            if ((state_reg == WAIT) && trig) begin
               trig_addr  <= ptr_reg;
               start_addr <= ptr_reg - pretrig_reg;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with DEPTH=16 and ramp data equal
// to the sample index counted from the most recent arm.
module tb_adc_capture_ctrl;

   localparam int NCH = 2;
   localparam int DW  = 16;
   localparam int AW  = 4;
   localparam int DCW = 16;

   logic              clk = 1'b0;
   logic              aresetn = 1'b0;
   logic              in_valid = 1'b0;
   logic [NCH*DW-1:0] in_data = '0;
   logic              arm = 1'b0;
   logic              abort = 1'b0;
   logic              trig = 1'b0;
   logic [AW-1:0]     pretrig = '0;
   logic [DCW-1:0]    decim = '0;
   logic [NCH-1:0]    chen = '0;
   logic [AW-1:0]     bram_addr;
   logic [NCH*DW-1:0] bram_data;
   logic [NCH-1:0]    bram_we;
   logic              busy;
   logic              done;
   logic [AW-1:0]     start_addr;
   logic [AW-1:0]     trig_addr;

   int tests_run = 0;
   int tests_failed = 0;
   int sample = 0;

   // Write log, cleared by pulsing clr while no write is in flight.
   logic          clr = 1'b0;
   int            wr_count;
   int            hits [16];
   logic          we0_seen;
   logic [DW-1:0] mem0 [16];
   logic [DW-1:0] mem1 [16];

   always #5 clk = ~clk;

   adc_capture_ctrl #(
      .NCH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DECIM_WIDTH(DCW)
   ) dut (
      .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_data(in_data),
      .arm(arm), .abort(abort), .trig(trig), .pretrig(pretrig), .decim(decim),
      .chen(chen), .bram_addr(bram_addr), .bram_data(bram_data), .bram_we(bram_we),
      .busy(busy), .done(done), .start_addr(start_addr), .trig_addr(trig_addr)
   );

   always @(negedge clk) begin
      if (clr) begin
         wr_count <= 0;
         we0_seen <= 1'b0;
         for (int a = 0; a < 16; a++) hits[a] <= 0;
      end else if (bram_we != '0) begin
         wr_count        <= wr_count + 1;
         hits[bram_addr] <= hits[bram_addr] + 1;
         if (bram_we[0]) begin
            we0_seen        <= 1'b1;
            mem0[bram_addr] <= bram_data[DW-1:0];
         end
         if (bram_we[1]) mem1[bram_addr] <= bram_data[2*DW-1:DW];
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic t, input logic ab = 1'b0);
      in_valid = 1'b1;
      in_data  = {NCH{DW'(sample)}};
      trig     = t;
      abort    = ab;
      step();
      sample++;
      in_valid = 1'b0;
      trig     = 1'b0;
      abort    = 1'b0;
   endtask

   task automatic do_arm(input int p, input int d, input logic [NCH-1:0] c);
      pretrig = AW'(p);
      decim   = DCW'(d);
      chen    = c;
      arm     = 1'b1;
      step();
      arm     = 1'b0;
      sample  = 0;
   endtask

   task automatic clear_log();
      clr = 1'b1;
      @(negedge clk);
      #1 clr = 1'b0;
      step();
   endtask

   int once;

   initial begin
      // Reset state
      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_we", bram_we, 0);
      check("rst_addr", bram_addr, 0);
      check("rst_trig_addr", trig_addr, 0);
      check("rst_start_addr", start_addr, 0);
      aresetn = 1'b1;
      step();

      // 1: pretrig=4, trigger on sample 10. PRE 0..3, WAIT 4..10, POST 11..21
      // gives 22 writes; the final 16 (samples 6..21) form the buffer.
      clear_log();
      do_arm(4, 0, 2'b11);
      check("t1_busy", busy, 1);
      for (int i = 0; i < 10; i++) send(1'b0);
      send(1'b1);
      for (int i = 0; i < 11; i++) send(1'b0);
      check("t1_last_we", bram_we, 3);
      check("t1_done_early", done, 0);
      step();
      check("t1_done", done, 1);
      check("t1_busy_end", busy, 0);
      check("t1_trig_addr", trig_addr, 10);
      check("t1_start_addr", start_addr, 6);
      send(1'b0);
      check("t1_writes", wr_count, 22);
      check("t1_oldest", mem0[6], 6);
      check("t1_newest", mem0[5], 21);
      check("t1_ch1_trig", mem1[10], 10);

      // 2: pretrig=0, trigger on first sample; every address once.
      clear_log();
      do_arm(0, 0, 2'b11);
      check("t2_busy", busy, 1);
      check("t2_done_cleared", done, 0);
      send(1'b1);
      for (int i = 0; i < 15; i++) send(1'b0);
      step();
      check("t2_done", done, 1);
      check("t2_trig_addr", trig_addr, 0);
      check("t2_start_addr", start_addr, 0);
      once = 0;
      for (int a = 0; a < 16; a++) if (hits[a] == 1) once++;
      check("t2_addr_once", once, 16);
      check("t2_writes", wr_count, 16);

      // 3: decim=2 keeps samples 0,3,6 of 9 continuous valid samples.
      clear_log();
      do_arm(4, 2, 2'b11);
      for (int i = 0; i < 9; i++) begin
         send(1'b0);
         check($sformatf("t3_we_s%0d", i), bram_we, (i % 3 == 0) ? 3 : 0);
      end
      step();
      check("t3_writes", wr_count, 3);
      check("t3_mem0", mem0[0], 0);
      check("t3_mem1", mem0[1], 3);
      check("t3_mem2", mem0[2], 6);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t3_abort_busy", busy, 0);

      // 4: trigs in PRE ignored; trigger on sample 20 lands at address 4.
      clear_log();
      do_arm(4, 0, 2'b11);
      for (int i = 0; i < 20; i++) send(i < 4);
      check("t4_busy_wait", busy, 1);
      send(1'b1);
      for (int i = 0; i < 11; i++) send(1'b0);
      step();
      check("t4_done", done, 1);
      check("t4_trig_addr", trig_addr, 4);
      check("t4_start_addr", start_addr, 0);
      check("t4_trig_data", mem0[4], 20);
      check("t4_oldest", mem0[0], 16);

      // 5: chen=2'b10 and the deepest pretrig the 4-bit port carries (15),
      // so nothing is written after the trigger.
      clear_log();
      do_arm(15, 0, 2'b10);
      for (int i = 0; i < 15; i++) send(1'b0);
      send(1'b1);
      check("t5_trig_we", bram_we, 2);
      send(1'b0);
      check("t5_done", done, 1);
      check("t5_post_we", bram_we, 0);
      check("t5_trig_addr", trig_addr, 15);
      check("t5_start_addr", start_addr, 0);
      step();
      check("t5_writes", wr_count, 16);
      check("t5_we0_never", we0_seen, 0);
      check("t5_ch1_trig", mem1[15], 15);

      // 6a: abort in WAIT; the sample with abort is not written.
      clear_log();
      do_arm(2, 0, 2'b11);
      send(1'b0);
      send(1'b0);
      send(1'b0);
      send(1'b0, 1'b1);
      check("t6_abort_busy", busy, 0);
      check("t6_abort_done", done, 0);
      check("t6_abort_we", bram_we, 0);
      send(1'b0);
      send(1'b1);
      step();
      check("t6_abort_writes", wr_count, 3);

      // arm together with abort stays idle
      arm   = 1'b1;
      abort = 1'b1;
      step();
      arm   = 1'b0;
      abort = 1'b0;
      check("t6_arm_abort", busy, 0);

      // 6b: reset during POST, then a normal capture.
      clear_log();
      do_arm(4, 0, 2'b11);
      for (int i = 0; i < 4; i++) send(1'b0);
      send(1'b1);
      for (int i = 0; i < 3; i++) send(1'b0);
      aresetn = 1'b0;
      step();
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_we", bram_we, 0);
      check("t6_rst_trig_addr", trig_addr, 0);
      check("t6_rst_start_addr", start_addr, 0);
      check("t6_rst_addr", bram_addr, 0);
      aresetn = 1'b1;
      clear_log();
      do_arm(0, 0, 2'b11);
      send(1'b1);
      for (int i = 0; i < 15; i++) send(1'b0);
      step();
      check("t6_rearm_done", done, 1);
      check("t6_rearm_trig_addr", trig_addr, 0);
      step();
      check("t6_rearm_writes", wr_count, 16);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
